// File: rtl/lbp_host_mem_if.sv
// Engine-side bus between the LBP engine (master) and the host memory model (slave).
interface lbp_host_mem_if #(
    parameter int unsigned AW = 14
);
    logic          gray_ready;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic [7:0]    gray_data;
    logic          lbp_valid;
    logic [AW-1:0] lbp_addr;
    logic [7:0]    lbp_data;
    logic          finish;

    modport master (
        input  gray_ready, gray_data,
        output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );

    modport slave (
        output gray_ready, gray_data,
        input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );
endinterface

// File: rtl/lbp_host_mem.sv
// Host memory model for the LBP engine: serves gray pixels, captures LBP results, checks the frame.
// Optional macro BORDER_CHECK_EN flags result writes that land on the image border.
module lbp_host_mem #(
    parameter int unsigned IMG_W   = 128,
    parameter int unsigned IMG_H   = 128,
    parameter int unsigned AW      = 14,
    parameter int unsigned EXP_CNT = 15876
) (
    input  logic          clk,
    input  logic          reset,
    lbp_host_mem_if.slave bus,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [7:0]    load_data,
    input  logic          start,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW:0]   wr_count,
    output logic          done,
    output logic          err_proto,
    output logic          err_count
);
    localparam int unsigned PIX = IMG_W * IMG_H;
    localparam int unsigned CW  = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_SERVE, S_DONE} state_t;

    state_t        state_q, state_d;
    logic          gray_ready_q, gray_ready_d;
    logic          done_q, done_d;
    logic          err_proto_q, err_proto_d;
    logic          err_count_q, err_count_d;
    logic [CW-1:0] wr_count_q, wr_count_d;
    logic [CW-1:0] cnt_inc_c;
    logic [CW-1:0] final_cnt_c;
    logic          img_we, lbp_we;
    logic          border_c;

    logic [7:0] img_mem [PIX];
    logic [7:0] lbp_mem [PIX];

`ifdef BORDER_CHECK_EN
    logic [AW-1:0] row_c, col_c;
    assign row_c    = AW'(bus.lbp_addr / AW'(IMG_W));
    assign col_c    = AW'(bus.lbp_addr % AW'(IMG_W));
    assign border_c = (row_c == '0) || (row_c == AW'(IMG_H - 1)) ||
                      (col_c == '0) || (col_c == AW'(IMG_W - 1));
`else
    assign border_c = 1'b0;
`endif

    // State and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            gray_ready_q <= 1'b0;
            done_q       <= 1'b0;
            err_proto_q  <= 1'b0;
            err_count_q  <= 1'b0;
            wr_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            gray_ready_q <= gray_ready_d;
            done_q       <= done_d;
            err_proto_q  <= err_proto_d;
            err_count_q  <= err_count_d;
            wr_count_q   <= wr_count_d;
        end
    end

    // Next-state: a start seen in SERVE is a protocol error and is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)      state_d = S_SERVE;
            S_SERVE: if (bus.finish) state_d = S_DONE;
            S_DONE:  if (start)      state_d = S_SERVE;
            default: state_d = S_IDLE;
        endcase
    end

    assign cnt_inc_c   = (wr_count_q == '1) ? wr_count_q : wr_count_q + CW'(1);
    assign final_cnt_c = bus.lbp_valid ? cnt_inc_c : wr_count_q;

    // Outputs, memory write enables and error detection
    always_comb begin
        img_we       = 1'b0;
        lbp_we       = 1'b0;
        wr_count_d   = wr_count_q;
        err_proto_d  = err_proto_q;
        err_count_d  = err_count_q;
        gray_ready_d = (state_d == S_SERVE);
        done_d       = (state_d == S_DONE);
        case (state_q)
            S_IDLE: begin
                img_we = load_en;
                if (bus.gray_req || bus.lbp_valid) err_proto_d = 1'b1;
                if (start) wr_count_d = '0;
            end
            S_SERVE: begin
                if (bus.lbp_valid) begin
                    lbp_we     = 1'b1;
                    wr_count_d = cnt_inc_c;
                    if (border_c) err_proto_d = 1'b1;
                end
                if (load_en || start) err_proto_d = 1'b1;
                if (bus.finish && (final_cnt_c != CW'(EXP_CNT))) err_count_d = 1'b1;
            end
            S_DONE: begin
                if (bus.gray_req || bus.lbp_valid || load_en) err_proto_d = 1'b1;
                if (start) wr_count_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (img_we) img_mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (lbp_we) lbp_mem[bus.lbp_addr] <= bus.lbp_data;
    end

    assign bus.gray_data  = (state_q == S_SERVE && bus.gray_req) ? img_mem[bus.gray_addr] : 8'h00;
    assign bus.gray_ready = gray_ready_q;
    assign rd_data        = lbp_mem[rd_addr];
    assign wr_count       = wr_count_q;
    assign done           = done_q;
    assign err_proto      = err_proto_q;
    assign err_count      = err_count_q;
endmodule

// File: tb/tb_lbp_host_mem.sv
// Directed bench for lbp_host_mem: table of single-cycle vectors plus multi-cycle frame sequences.
module tb_lbp_host_mem;
    localparam int unsigned AW    = 14;
    localparam int unsigned IMG_W = 128;
    localparam int unsigned IMG_H = 128;
    localparam int unsigned NV    = 18;
`ifdef BORDER_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [7:0]    load_data = '0;
    logic          start = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
    logic [AW:0]   wr_count;
    logic          done, err_proto, err_count;

    lbp_host_mem_if #(.AW(AW)) bus ();

    lbp_host_mem #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .EXP_CNT(15876)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_count(wr_count), .done(done), .err_proto(err_proto), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          load_en;
        logic [AW-1:0] load_addr;
        logic [7:0]    load_data;
        logic          start;
        logic          gray_req;
        logic [AW-1:0] gray_addr;
        logic          lbp_valid;
        logic [AW-1:0] lbp_addr;
        logic [7:0]    lbp_data;
        logic          finish;
        logic [AW-1:0] rd_addr;
        logic          chk_rd;
        logic          e_ready;
        logic [7:0]    e_gray;
        logic          e_done;
        logic [AW:0]   e_wr;
        logic          e_errp;
        logic          e_errc;
        logic [7:0]    e_rd;
    } vec_t;

    vec_t tbl [NV];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bus();
        bus.gray_req  = 1'b0;
        bus.gray_addr = '0;
        bus.lbp_valid = 1'b0;
        bus.lbp_addr  = '0;
        bus.lbp_data  = '0;
        bus.finish    = 1'b0;
        load_en       = 1'b0;
        start         = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // n interior writes of data=addr[7:0]; optionally the last one shares the finish cycle
    task automatic frame(input int n, input bit last_with_finish);
        int k = 0;
        logic [AW-1:0] a;
        for (int r = 1; r < IMG_H - 1 && k < n; r++) begin
            for (int c = 1; c < IMG_W - 1 && k < n; c++) begin
                a = AW'(r * IMG_W + c);
                bus.lbp_valid = 1'b1;
                bus.lbp_addr  = a;
                bus.lbp_data  = a[7:0];
                k++;
                bus.finish = (k == n) && last_with_finish;
                tick();
            end
        end
        bus.lbp_valid = 1'b0;
        if (!last_with_finish) begin
            bus.finish = 1'b1;
            tick();
        end
        bus.finish = 1'b0;
    endtask

    function automatic vec_t mk(
        input logic le, input logic [AW-1:0] la, input logic [7:0] ld, input logic st,
        input logic gq, input logic [AW-1:0] ga, input logic lv, input logic [AW-1:0] lba,
        input logic [7:0] lbd, input logic fi, input logic [AW-1:0] ra, input logic cr,
        input logic er, input logic [7:0] eg, input logic ed, input logic [AW:0] ew,
        input logic ep, input logic ec, input logic [7:0] erd);
        vec_t v;
        v.load_en = le; v.load_addr = la; v.load_data = ld; v.start = st;
        v.gray_req = gq; v.gray_addr = ga; v.lbp_valid = lv; v.lbp_addr = lba;
        v.lbp_data = lbd; v.finish = fi; v.rd_addr = ra; v.chk_rd = cr;
        v.e_ready = er; v.e_gray = eg; v.e_done = ed; v.e_wr = ew;
        v.e_errp = ep; v.e_errc = ec; v.e_rd = erd;
        return v;
    endfunction

    initial begin
        clear_bus();
        // expected status is the pre-edge value; gray_data/rd_data follow this cycle's inputs
        //               le la   ld     st gq ga   lv la   ld     fi ra   cr  rdy gray  dn wr ep  ec rd
        tbl[0]  = mk(1, 5,   8'hA5, 1, 0, 0,   0, 0,   8'h00, 0, 0,   0,  0, 8'h00, 0, 0, 0,  0, 8'h00);
        tbl[1]  = mk(0, 0,   8'h00, 0, 1, 129, 0, 0,   8'h00, 0, 0,   0,  1, 8'h81, 0, 0, 0,  0, 8'h00);
        tbl[2]  = mk(0, 0,   8'h00, 0, 1, 5,   0, 0,   8'h00, 0, 0,   0,  1, 8'hA5, 0, 0, 0,  0, 8'h00);
        tbl[3]  = mk(0, 0,   8'h00, 0, 0, 129, 0, 0,   8'h00, 0, 0,   0,  1, 8'h00, 0, 0, 0,  0, 8'h00);
        tbl[4]  = mk(0, 0,   8'h00, 0, 0, 0,   1, 200, 8'h3C, 0, 200, 0,  1, 8'h00, 0, 0, 0,  0, 8'h00);
        tbl[5]  = mk(0, 0,   8'h00, 0, 0, 0,   0, 0,   8'h00, 0, 200, 1,  1, 8'h00, 0, 1, 0,  0, 8'h3C);
        tbl[6]  = mk(0, 0,   8'h00, 0, 0, 0,   1, 0,   8'h11, 0, 0,   0,  1, 8'h00, 0, 1, 0,  0, 8'h00);
        tbl[7]  = mk(0, 0,   8'h00, 0, 0, 0,   0, 0,   8'h00, 0, 0,   1,  1, 8'h00, 0, 2, BC, 0, 8'h11);
        tbl[8]  = mk(1, 129, 8'hEE, 0, 0, 0,   0, 0,   8'h00, 0, 0,   0,  1, 8'h00, 0, 2, BC, 0, 8'h00);
        tbl[9]  = mk(0, 0,   8'h00, 0, 1, 129, 0, 0,   8'h00, 0, 0,   0,  1, 8'h81, 0, 2, 1,  0, 8'h00);
        tbl[10] = mk(0, 0,   8'h00, 1, 0, 0,   0, 0,   8'h00, 0, 0,   0,  1, 8'h00, 0, 2, 1,  0, 8'h00);
        tbl[11] = mk(0, 0,   8'h00, 0, 0, 0,   1, 300, 8'h77, 1, 0,   0,  1, 8'h00, 0, 2, 1,  0, 8'h00);
        tbl[12] = mk(0, 0,   8'h00, 0, 0, 0,   0, 0,   8'h00, 0, 300, 1,  0, 8'h00, 1, 3, 1,  1, 8'h77);
        tbl[13] = mk(0, 0,   8'h00, 0, 1, 129, 0, 0,   8'h00, 0, 0,   0,  0, 8'h00, 1, 3, 1,  1, 8'h00);
        tbl[14] = mk(0, 0,   8'h00, 0, 0, 0,   1, 200, 8'h99, 0, 0,   0,  0, 8'h00, 1, 3, 1,  1, 8'h00);
        tbl[15] = mk(0, 0,   8'h00, 0, 0, 0,   0, 0,   8'h00, 0, 200, 1,  0, 8'h00, 1, 3, 1,  1, 8'h3C);
        tbl[16] = mk(0, 0,   8'h00, 1, 0, 0,   0, 0,   8'h00, 0, 0,   0,  0, 8'h00, 1, 3, 1,  1, 8'h00);
        tbl[17] = mk(0, 0,   8'h00, 0, 0, 0,   0, 0,   8'h00, 0, 0,   0,  1, 8'h00, 0, 0, 1,  1, 8'h00);

        do_reset();
        chk("rst_ready", 32'(bus.gray_ready), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_wr",    32'(wr_count), 0);
        chk("rst_errp",  32'(err_proto), 0);
        chk("rst_errc",  32'(err_count), 0);

        // preload img[k] = k[7:0]
        for (int k = 0; k < IMG_W * IMG_H; k++) begin
            load_en   = 1'b1;
            load_addr = AW'(k);
            load_data = 8'(k);
            tick();
        end
        load_en = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            load_en       = tbl[i].load_en;
            load_addr     = tbl[i].load_addr;
            load_data     = tbl[i].load_data;
            start         = tbl[i].start;
            bus.gray_req  = tbl[i].gray_req;
            bus.gray_addr = tbl[i].gray_addr;
            bus.lbp_valid = tbl[i].lbp_valid;
            bus.lbp_addr  = tbl[i].lbp_addr;
            bus.lbp_data  = tbl[i].lbp_data;
            bus.finish    = tbl[i].finish;
            rd_addr       = tbl[i].rd_addr;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(bus.gray_ready), 32'(tbl[i].e_ready));
            chk($sformatf("v%0d_gray", i),  32'(bus.gray_data),  32'(tbl[i].e_gray));
            chk($sformatf("v%0d_done", i),  32'(done),           32'(tbl[i].e_done));
            chk($sformatf("v%0d_wr", i),    32'(wr_count),       32'(tbl[i].e_wr));
            chk($sformatf("v%0d_errp", i),  32'(err_proto),      32'(tbl[i].e_errp));
            chk($sformatf("v%0d_errc", i),  32'(err_count),      32'(tbl[i].e_errc));
            if (tbl[i].chk_rd) chk($sformatf("v%0d_rd", i), 32'(rd_data), 32'(tbl[i].e_rd));
        end
        @(negedge clk);
        clear_bus();

        // asynchronous reset while serving; image survives
        #2 reset = 1'b0;
        #1;
        chk("arst_ready", 32'(bus.gray_ready), 0);
        chk("arst_errp",  32'(err_proto), 0);
        chk("arst_errc",  32'(err_count), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("arst_idle_ready", 32'(bus.gray_ready), 0);
        chk("arst_wr", 32'(wr_count), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_ready", 32'(bus.gray_ready), 1);
        bus.gray_req  = 1'b1;
        bus.gray_addr = 5;
        #1 chk("img_kept", 32'(bus.gray_data), 32'h0A5);
        bus.gray_addr = 129;
        #1 chk("img_load_ignored", 32'(bus.gray_data), 32'h081);
        bus.gray_req = 1'b0;

        // full frame with the exact write count
        frame(15876, 1'b0);
        chk("full_done", 32'(done), 1);
        chk("full_wr",   32'(wr_count), 15876);
        chk("full_errc", 32'(err_count), 0);
        chk("full_errp", 32'(err_proto), 0);
        rd_addr = 130;
        #1 chk("full_rd130", 32'(rd_data), 32'h082);

        // short frame from DONE
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("short_start_done", 32'(done), 0);
        chk("short_start_wr",   32'(wr_count), 0);
        frame(15875, 1'b0);
        chk("short_done", 32'(done), 1);
        chk("short_errc", 32'(err_count), 1);
        chk("short_wr",   32'(wr_count), 15875);

        // last write in the finish cycle still counts
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        frame(15876, 1'b1);
        chk("fin_wr_done", 32'(done), 1);
        chk("fin_wr_cnt",  32'(wr_count), 15876);
        chk("fin_wr_errc", 32'(err_count), 0);

        // write in IDLE is dropped
        do_reset();
        bus.lbp_valid = 1'b1;
        bus.lbp_addr  = 200;
        bus.lbp_data  = 8'h00;
        tick();
        bus.lbp_valid = 1'b0;
        rd_addr = 200;
        #1;
        chk("idle_wr_errp", 32'(err_proto), 1);
        chk("idle_wr_cnt",  32'(wr_count), 0);
        chk("idle_wr_mem",  32'(rd_data), 32'h0C8);

        // border write is stored and counted
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.lbp_valid = 1'b1;
        bus.lbp_addr  = 0;
        bus.lbp_data  = 8'h5A;
        tick();
        bus.lbp_valid = 1'b0;
        rd_addr = 0;
        #1;
        chk("border_errp", 32'(err_proto), 32'(BC));
        chk("border_wr",   32'(wr_count), 1);
        chk("border_mem",  32'(rd_data), 32'h05A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
